// File: rtl/adaptive_prob_lookup.sv
// Adaptive probability table for context-based entropy coding.
// A table of CTX_NUM * 2^SYM_W probabilities is filled with a linear ramp
// after reset or flush. Once filled, the block serves registered lookups
// with a valid/ready handshake and single-cycle read-modify-write updates.
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | writing one initial table entry per cycle, lookups blocked
// RUN   | table valid: lookups served, updates applied
module adaptive_prob_lookup #(
  parameter int                SYM_W       = 8,
  parameter int                PROB_W      = 16,
  parameter int                CTX_NUM     = 2,
  parameter logic [PROB_W-1:0] INIT_BASE   = 16'h1000,
  parameter logic [PROB_W-1:0] INIT_STEP   = 16'h0100,
  parameter int                ADAPT_SHIFT = 4,
  localparam int               CTX_W       = (CTX_NUM > 1) ? $clog2(CTX_NUM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              lookup_valid,
  output logic              lookup_ready,
  input  logic [CTX_W-1:0]  lookup_ctx,
  input  logic [SYM_W-1:0]  lookup_sym,
  output logic              prob_valid,
  input  logic              prob_ready,
  output logic [PROB_W-1:0] symbol_prob,
  output logic [CTX_W-1:0]  prob_ctx,
  input  logic              update_valid,
  input  logic [CTX_W-1:0]  update_ctx,
  input  logic [SYM_W-1:0]  update_sym,
  input  logic              update_inc,
  output logic              init_done
);

  localparam int                ADDR_W    = CTX_W + SYM_W;
  localparam int                DEPTH     = CTX_NUM << SYM_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic [PROB_W-1:0] table_mem [0:(2**ADDR_W)-1];

  logic              in_run;
  logic              lookup_acc;
  logic              update_en;
  logic [ADDR_W-1:0] lookup_addr;
  logic [ADDR_W-1:0] update_addr;
  logic [PROB_W-1:0] upd_old;
  logic [PROB_W-1:0] upd_new;
  logic [PROB_W-1:0] init_val;

  // Handshake qualification, address formation and the adaptation arithmetic.
  // ~p equals (2^PROB_W-1 - p), so neither direction can wrap.
  always_comb begin
    in_run       = (state == ST_RUN);
    lookup_ready = in_run && (!prob_valid || prob_ready);
    lookup_acc   = lookup_valid && lookup_ready && !flush;
    update_en    = update_valid && in_run && !flush;
    lookup_addr  = {lookup_ctx, lookup_sym};
    update_addr  = {update_ctx, update_sym};
    upd_old      = table_mem[update_addr];
    upd_new      = update_inc ? (upd_old + ((~upd_old) >> ADAPT_SHIFT))
                              : (upd_old - (upd_old >> ADAPT_SHIFT));
    init_val     = INIT_BASE + PROB_W'(init_cnt[SYM_W-1:0]) * INIT_STEP;
  end

  assign init_done = in_run;

  // Sequencer: reset/flush restart the fill; the last fill write also moves to RUN.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_ADDR) begin
        state <= ST_RUN;
      end
    end
  end

  // Table writes: fill ramp during INIT, adapted value during RUN.
  always_ff @(posedge clk) begin
    if (!reset && !flush && (state == ST_INIT)) begin
      table_mem[init_cnt] <= init_val;
    end else if (!reset && update_en) begin
      table_mem[update_addr] <= upd_new;
    end
  end

  // Result register: reads the pre-update entry, holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      prob_valid  <= 1'b0;
      symbol_prob <= '0;
      prob_ctx    <= '0;
    end else if (flush || !in_run) begin
      prob_valid <= 1'b0;
    end else if (lookup_acc) begin
      prob_valid  <= 1'b1;
      symbol_prob <= table_mem[lookup_addr];
      prob_ctx    <= lookup_ctx;
    end else if (prob_ready) begin
      prob_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adaptive_prob_lookup.sv
// Scoreboard bench for adaptive_prob_lookup with a behavioural table model.
module tb_adaptive_prob_lookup;

  localparam int NCTX  = 2;
  localparam int NSYM  = 256;
  localparam int BASE  = 'h1000;
  localparam int STEP  = 'h0100;
  localparam int DIV   = 16;
  localparam int PMAX  = 65535;
  localparam int NINIT = NCTX * NSYM;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        lookup_valid;
  logic        lookup_ready;
  logic [0:0]  lookup_ctx;
  logic [7:0]  lookup_sym;
  logic        prob_valid;
  logic        prob_ready;
  logic [15:0] symbol_prob;
  logic [0:0]  prob_ctx;
  logic        update_valid;
  logic [0:0]  update_ctx;
  logic [7:0]  update_sym;
  logic        update_inc;
  logic        init_done;

  adaptive_prob_lookup dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .lookup_valid (lookup_valid),
    .lookup_ready (lookup_ready),
    .lookup_ctx   (lookup_ctx),
    .lookup_sym   (lookup_sym),
    .prob_valid   (prob_valid),
    .prob_ready   (prob_ready),
    .symbol_prob  (symbol_prob),
    .prob_ctx     (prob_ctx),
    .update_valid (update_valid),
    .update_ctx   (update_ctx),
    .update_sym   (update_sym),
    .update_inc   (update_inc),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  model_tab [0:NCTX-1][0:NSYM-1];
  bit  model_run = 0;
  int  exp_q [$];
  bit  held_valid = 0;
  logic [15:0] held_prob;
  logic [0:0]  held_ctx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_init();
    for (int c = 0; c < NCTX; c++)
      for (int s = 0; s < NSYM; s++)
        model_tab[c][s] = (BASE + s * STEP) % (PMAX + 1);
  endfunction

  function automatic void model_update(input int c, input int s, input bit inc);
    int p;
    p = model_tab[c][s];
    if (inc) p = p + (PMAX - p) / DIV;
    else     p = p - p / DIV;
    model_tab[c][s] = p;
  endfunction

  // Drive one cycle of inputs, record what the model expects, step past the edge.
  task automatic drive(input bit lv, input int lc, input int ls,
                       input bit uv, input int uc, input int us, input bit ui,
                       input bit pr, input bit fl, output bit acc);
    lookup_valid = lv;  lookup_ctx = lc[0:0]; lookup_sym = ls[7:0];
    update_valid = uv;  update_ctx = uc[0:0]; update_sym = us[7:0];
    update_inc   = ui;  prob_ready = pr;      flush      = fl;
    #1;
    acc = lv && (lookup_ready === 1'b1) && !fl;
    if (acc) exp_q.push_back(lc * 65536 + model_tab[lc][ls]);
    if (uv && model_run && !fl) model_update(uc, us, ui);
    if (fl) begin
      model_init();
      model_run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, a);
  endtask

  task automatic lookup(input int c, input int s);
    bit a;
    drive(1, c, s, 0, 0, 0, 0, 1, 0, a);
    check("lookup_accept", a, 1);
  endtask

  task automatic update(input int c, input int s, input bit inc);
    bit a;
    drive(0, 0, 0, 1, c, s, inc, 1, 0, a);
  endtask

  task automatic wait_init(input string name);
    int cnt;
    lookup_valid = 0; update_valid = 0; flush = 0; prob_ready = 1;
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(name, cnt, NINIT);
    check({name, "_ready"}, lookup_ready, 1);
    model_run = 1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1;
    lookup_valid = 0; update_valid = 0; flush = 0; prob_ready = 1;
    repeat (n) @(posedge clk);
    #1;
    exp_q.delete();
    model_init();
    model_run = 0;
  endtask

  // Monitor: pops the scoreboard on every completed transfer, checks stall stability.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && prob_valid === 1'b1) begin
        if (held_valid) begin
          check("hold_prob", symbol_prob, held_prob);
          check("hold_ctx", prob_ctx, held_ctx);
        end
        if (prob_ready === 1'b1) begin
          held_valid = 0;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got prob 0x%0h ctx %0d with nothing expected", symbol_prob, prob_ctx);
          end else begin
            n_tests--;
            e = exp_q.pop_front();
            check("result_prob", symbol_prob, e[15:0]);
            check("result_ctx", prob_ctx, e[31:16]);
          end
        end else begin
          held_valid = 1;
          held_prob  = symbol_prob;
          held_ctx   = prob_ctx;
        end
      end else begin
        held_valid = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    model_init();
    flush = 0; lookup_valid = 0; lookup_ctx = 0; lookup_sym = 0;
    update_valid = 0; update_ctx = 0; update_sym = 0; update_inc = 0; prob_ready = 1;

    // Reset state
    apply_reset(3);
    check("rst_prob_valid", prob_valid, 0);
    check("rst_symbol_prob", symbol_prob, 0);
    check("rst_prob_ctx", prob_ctx, 0);
    check("rst_init_done", init_done, 0);
    check("rst_lookup_ready", lookup_ready, 0);
    reset = 0;
    wait_init("init_len_first");

    // Back-to-back lookups across the ramp wrap point
    lookup(1, 'h05);
    lookup(1, 'hEF);
    lookup(1, 'hF0);
    idle(2);

    // Increment adaptation, then decrement from a fresh table (flush restarted mid-fill)
    update(0, 'h05, 1);
    lookup(0, 'h05);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, a);
    idle(200);
    check("init_busy_mid", init_done, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, a);
    wait_init("init_len_reflush");
    update(0, 'h05, 0);
    lookup(0, 'h05);
    lookup(1, 'h05);
    idle(2);

    // Same-cycle lookup and update: pre-update value first, updated value next
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, a);
    wait_init("init_len_flush2");
    drive(1, 0, 'h05, 1, 0, 'h05, 1, 1, 0, a);
    check("same_cycle_accept", a, 1);
    lookup(0, 'h05);
    idle(2);

    // Back-pressure: three stalled cycles with a request waiting
    lookup(1, 'h10);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 'h20, 0, 0, 0, 0, 0, 0, a);
      check("stall_ready_low", a, 0);
    end
    drive(1, 0, 'h20, 0, 0, 0, 0, 1, 0, a);
    check("stall_release_accept", a, 1);
    idle(2);

    // Randomized traffic with address collisions
    for (int i = 0; i < 400; i++) begin
      int ls, us;
      ls = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      us = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), ls,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1), us, $urandom_range(0, 1),
            $urandom_range(0, 3) != 0, 0, a);
    end
    idle(3);

    // Reset mid-transfer discards the pending result
    lookup(0, 'h33);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    apply_reset(2);
    check("rst2_prob_valid", prob_valid, 0);
    check("rst2_symbol_prob", symbol_prob, 0);
    check("rst2_init_done", init_done, 0);
    check("rst2_lookup_ready", lookup_ready, 0);
    reset = 0;
    wait_init("init_len_after_rst2");

    // Updates, flush beating a simultaneous update and lookup, reset mid-fill
    update(0, 'h05, 1);
    update(0, 'h05, 0);
    lookup(0, 'h05);
    idle(2);
    drive(1, 0, 'h05, 1, 0, 'h05, 1, 1, 1, a);
    idle(1);
    check("flush_ready_low", lookup_ready, 0);
    idle(100);
    check("flush_init_busy", init_done, 0);
    apply_reset(2);
    reset = 0;
    wait_init("init_len_after_rst3");
    lookup(0, 'h05);
    lookup(1, 'h05);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
